// File: rtl/axi_rw_bridge.sv
// axi_rw_bridge: arbitrates fetch and load/store requests onto one AXI4 master.
// Define AXI_BRIDGE_ERR_EN to add if_err_o/mem_err_o response-error flags.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module axi_rw_bridge #(
  parameter int ADDR_W = `AXI_ADDR_WIDTH,
  parameter int DATA_W = `AXI_DATA_WIDTH,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ready_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                mem_valid_i,
  input  logic                mem_wen_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  input  logic [2:0]          mem_size_i,
  output logic                mem_ready_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
`ifdef AXI_BRIDGE_ERR_EN
  output logic                if_err_o,
  output logic                mem_err_o,
`endif
  output logic [ID_W-1:0]     axi_aw_id_o,
  output logic [ADDR_W-1:0]   axi_aw_addr_o,
  output logic [7:0]          axi_aw_len_o,
  output logic [2:0]          axi_aw_size_o,
  output logic [1:0]          axi_aw_burst_o,
  output logic                axi_aw_lock_o,
  output logic [3:0]          axi_aw_cache_o,
  output logic [2:0]          axi_aw_prot_o,
  output logic [3:0]          axi_aw_qos_o,
  output logic [3:0]          axi_aw_region_o,
  output logic                axi_aw_user_o,
  output logic                axi_aw_valid_o,
  input  logic                axi_aw_ready_i,
  output logic [DATA_W-1:0]   axi_w_data_o,
  output logic [DATA_W/8-1:0] axi_w_strb_o,
  output logic                axi_w_last_o,
  output logic                axi_w_user_o,
  output logic                axi_w_valid_o,
  input  logic                axi_w_ready_i,
  input  logic [ID_W-1:0]     axi_b_id_i,
  input  logic [1:0]          axi_b_resp_i,
  input  logic                axi_b_user_i,
  input  logic                axi_b_valid_i,
  output logic                axi_b_ready_o,
  output logic [ID_W-1:0]     axi_ar_id_o,
  output logic [ADDR_W-1:0]   axi_ar_addr_o,
  output logic [7:0]          axi_ar_len_o,
  output logic [2:0]          axi_ar_size_o,
  output logic [1:0]          axi_ar_burst_o,
  output logic                axi_ar_lock_o,
  output logic [3:0]          axi_ar_cache_o,
  output logic [2:0]          axi_ar_prot_o,
  output logic [3:0]          axi_ar_qos_o,
  output logic [3:0]          axi_ar_region_o,
  output logic                axi_ar_user_o,
  output logic                axi_ar_valid_o,
  input  logic                axi_ar_ready_i,
  input  logic [ID_W-1:0]     axi_r_id_i,
  input  logic [DATA_W-1:0]   axi_r_data_i,
  input  logic [1:0]          axi_r_resp_i,
  input  logic                axi_r_last_i,
  input  logic                axi_r_user_i,
  input  logic                axi_r_valid_i,
  output logic                axi_r_ready_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t                r_state, w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata, r_if_rdata, r_mem_rdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [2:0]            r_size;
  logic                  r_is_mem, r_aw_done, r_w_done;
  logic                  r_if_ready, r_mem_ready;
  logic                  w_if_req, w_mem_req;
  logic                  w_aw_hs, w_w_hs, w_aw_ok, w_w_ok;

  // A requester still sees valid during its ready pulse; mask it so it is not re-served.
  assign w_mem_req = mem_valid_i & ~r_mem_ready;
  assign w_if_req  = if_valid_i & ~r_if_ready;
  assign w_aw_hs   = axi_aw_valid_o & axi_aw_ready_i;
  assign w_w_hs    = axi_w_valid_o & axi_w_ready_i;
  assign w_aw_ok   = r_aw_done | w_aw_hs;
  assign w_w_ok    = r_w_done | w_w_hs;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_mem_req)     w_next = mem_wen_i ? WR_REQ : RD_ADDR;
        else if (w_if_req) w_next = RD_ADDR;
      end
      RD_ADDR: if (axi_ar_ready_i)     w_next = RD_DATA;
      RD_DATA: if (axi_r_valid_i)      w_next = IDLE;
      WR_REQ:  if (w_aw_ok && w_w_ok)  w_next = WR_RESP;
      WR_RESP: if (axi_b_valid_i)      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    axi_ar_valid_o = 1'b0;
    axi_r_ready_o  = 1'b0;
    axi_aw_valid_o = 1'b0;
    axi_w_valid_o  = 1'b0;
    axi_b_ready_o  = 1'b0;
    unique case (r_state)
      RD_ADDR: axi_ar_valid_o = 1'b1;
      RD_DATA: axi_r_ready_o  = 1'b1;
      WR_REQ: begin
        axi_aw_valid_o = ~r_aw_done;
        axi_w_valid_o  = ~r_w_done;
      end
      WR_RESP: axi_b_ready_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_size      <= '0;
      r_is_mem    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (w_mem_req) begin
            r_is_mem <= 1'b1;
            r_addr   <= mem_addr_i;
            r_wdata  <= mem_wdata_i;
            r_wstrb  <= mem_wstrb_i;
            r_size   <= mem_size_i;
          end else if (w_if_req) begin
            r_is_mem <= 1'b0;
            r_addr   <= if_addr_i;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_size   <= 3'd3;
          end
        end
        RD_DATA: begin
          if (axi_r_valid_i) begin
            if (r_is_mem) begin
              r_mem_rdata <= axi_r_data_i;
              r_mem_ready <= 1'b1;
            end else begin
              r_if_rdata <= axi_r_data_i;
              r_if_ready <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        WR_RESP: if (axi_b_valid_i) r_mem_ready <= 1'b1;
        default: ;
      endcase
    end
  end

  assign if_ready_o  = r_if_ready;
  assign if_rdata_o  = r_if_rdata;
  assign mem_ready_o = r_mem_ready;
  assign mem_rdata_o = r_mem_rdata;

  assign axi_aw_id_o     = ID_W'(1);
  assign axi_aw_addr_o   = r_addr;
  assign axi_aw_len_o    = 8'd0;
  assign axi_aw_size_o   = r_size;
  assign axi_aw_burst_o  = 2'b01;
  assign axi_aw_lock_o   = 1'b0;
  assign axi_aw_cache_o  = 4'd0;
  assign axi_aw_prot_o   = 3'b000;
  assign axi_aw_qos_o    = 4'd0;
  assign axi_aw_region_o = 4'd0;
  assign axi_aw_user_o   = 1'b0;
  assign axi_w_data_o    = r_wdata;
  assign axi_w_strb_o    = r_wstrb;
  assign axi_w_last_o    = 1'b1;
  assign axi_w_user_o    = 1'b0;
  assign axi_ar_id_o     = ID_W'(r_is_mem);
  assign axi_ar_addr_o   = r_addr;
  assign axi_ar_len_o    = 8'd0;
  assign axi_ar_size_o   = r_size;
  assign axi_ar_burst_o  = 2'b01;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = 4'd0;
  assign axi_ar_prot_o   = 3'b000;
  assign axi_ar_qos_o    = 4'd0;
  assign axi_ar_region_o = 4'd0;
  assign axi_ar_user_o   = 1'b0;

`ifdef AXI_BRIDGE_ERR_EN
  logic r_if_err, r_mem_err;
  logic w_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_err  <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_if_err  <= 1'b0;
      r_mem_err <= 1'b0;
      if (r_state == RD_DATA && axi_r_valid_i) begin
        if (r_is_mem) r_mem_err <= |axi_r_resp_i;
        else          r_if_err  <= |axi_r_resp_i;
      end
      if (r_state == WR_RESP && axi_b_valid_i)
        r_mem_err <= |axi_b_resp_i;
    end
  end

  assign if_err_o  = r_if_err;
  assign mem_err_o = r_mem_err;
  assign w_unused  = ^{axi_b_id_i, axi_b_user_i, axi_r_id_i,
                       axi_r_last_i, axi_r_user_i};
`else
  logic w_unused;
  assign w_unused = ^{axi_b_id_i, axi_b_user_i, axi_r_id_i,
                      axi_r_last_i, axi_r_user_i,
                      axi_r_resp_i, axi_b_resp_i};
`endif

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Directed bench for axi_rw_bridge: fetch, arbitration, split store handshake,
// mid-read reset and (with AXI_BRIDGE_ERR_EN) response-error flagging.
`timescale 1ns/1ps

module tb_axi_rw_bridge;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_valid, if_ready, mem_valid, mem_wen, mem_ready;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] if_rdata, mem_rdata, mem_wdata;
  logic [7:0] mem_wstrb;
  logic [2:0] mem_size;
`ifdef AXI_BRIDGE_ERR_EN
  logic if_err, mem_err;
`endif
  logic [IW-1:0] aw_id, ar_id, b_id, r_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len, w_strb;
  logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
  logic aw_lock, ar_lock, aw_user, ar_user, w_user, w_last;
  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, r_last, r_user, b_user;
  logic [DW-1:0] w_data, r_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_rw_bridge #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_addr_i(if_addr),
    .if_ready_o(if_ready), .if_rdata_o(if_rdata),
    .mem_valid_i(mem_valid), .mem_wen_i(mem_wen),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_wstrb_i(mem_wstrb), .mem_size_i(mem_size),
    .mem_ready_o(mem_ready), .mem_rdata_o(mem_rdata),
`ifdef AXI_BRIDGE_ERR_EN
    .if_err_o(if_err), .mem_err_o(mem_err),
`endif
    .axi_aw_id_o(aw_id), .axi_aw_addr_o(aw_addr),
    .axi_aw_len_o(aw_len), .axi_aw_size_o(aw_size),
    .axi_aw_burst_o(aw_burst), .axi_aw_lock_o(aw_lock),
    .axi_aw_cache_o(aw_cache), .axi_aw_prot_o(aw_prot),
    .axi_aw_qos_o(aw_qos), .axi_aw_region_o(aw_region),
    .axi_aw_user_o(aw_user), .axi_aw_valid_o(aw_valid),
    .axi_aw_ready_i(aw_ready),
    .axi_w_data_o(w_data), .axi_w_strb_o(w_strb),
    .axi_w_last_o(w_last), .axi_w_user_o(w_user),
    .axi_w_valid_o(w_valid), .axi_w_ready_i(w_ready),
    .axi_b_id_i(b_id), .axi_b_resp_i(b_resp),
    .axi_b_user_i(b_user), .axi_b_valid_i(b_valid),
    .axi_b_ready_o(b_ready),
    .axi_ar_id_o(ar_id), .axi_ar_addr_o(ar_addr),
    .axi_ar_len_o(ar_len), .axi_ar_size_o(ar_size),
    .axi_ar_burst_o(ar_burst), .axi_ar_lock_o(ar_lock),
    .axi_ar_cache_o(ar_cache), .axi_ar_prot_o(ar_prot),
    .axi_ar_qos_o(ar_qos), .axi_ar_region_o(ar_region),
    .axi_ar_user_o(ar_user), .axi_ar_valid_o(ar_valid),
    .axi_ar_ready_i(ar_ready),
    .axi_r_id_i(r_id), .axi_r_data_i(r_data),
    .axi_r_resp_i(r_resp), .axi_r_last_i(r_last),
    .axi_r_user_i(r_user), .axi_r_valid_i(r_valid),
    .axi_r_ready_o(r_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 0; if_addr = '0;
    mem_valid = 0; mem_wen = 0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; mem_size = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
    b_id = '0; b_user = 0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = 2'b00;
    r_id = '0; r_last = 1; r_user = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_aw_valid", 64'(aw_valid), 64'd0);
    chk("rst_w_valid",  64'(w_valid),  64'd0);
    chk("rst_r_ready",  64'(r_ready),  64'd0);
    chk("rst_b_ready",  64'(b_ready),  64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    chk("rst_prot", 64'({ar_prot, aw_prot}), 64'd0);
    rst = 1'b0;

    // fetch with ar_ready two cycles late
    @(negedge clk);
    if_valid = 1; if_addr = 64'h8000_0000;
    @(negedge clk);
    chk("f_ar_valid", 64'(ar_valid), 64'd1);
    chk("f_ar_addr", ar_addr, 64'h8000_0000);
    chk("f_ar_id", 64'(ar_id), 64'd0);
    chk("f_ar_size", 64'(ar_size), 64'd3);
    chk("f_ar_len", 64'(ar_len), 64'd0);
    chk("f_ar_burst", 64'(ar_burst), 64'd1);
    @(negedge clk);
    chk("f_ar_hold", 64'(ar_valid), 64'd1);
    chk("f_ar_addr_hold", ar_addr, 64'h8000_0000);
    @(negedge clk);
    ar_ready = 1;
    @(negedge clk);
    ar_ready = 0;
    chk("f_ar_drop", 64'(ar_valid), 64'd0);
    chk("f_r_ready", 64'(r_ready), 64'd1);
    chk("f_no_early_ready", 64'(if_ready), 64'd0);
    r_valid = 1; r_data = 64'h0000_0013_0000_0093;
    @(negedge clk);
    chk("f_if_ready", 64'(if_ready), 64'd1);
    chk("f_if_rdata", if_rdata, 64'h0000_0013_0000_0093);
    chk("f_r_ready_off", 64'(r_ready), 64'd0);
    if_valid = 0; r_valid = 0;
    @(negedge clk);
    chk("f_if_ready_pulse", 64'(if_ready), 64'd0);
    chk("f_if_rdata_hold", if_rdata, 64'h0000_0013_0000_0093);
    chk("f_idle_ar", 64'(ar_valid), 64'd0);

    // simultaneous fetch + load: load goes first
    if_valid = 1; if_addr = 64'h8000_0040;
    mem_valid = 1; mem_wen = 0; mem_addr = 64'h8000_1000; mem_size = 3'd2;
    @(negedge clk);
    chk("arb_ar_addr", ar_addr, 64'h8000_1000);
    chk("arb_ar_id", 64'(ar_id), 64'd1);
    chk("arb_ar_size", 64'(ar_size), 64'd2);
    ar_ready = 1;
    @(negedge clk);
    ar_ready = 0;
    r_valid = 1; r_data = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("arb_mem_ready", 64'(mem_ready), 64'd1);
    chk("arb_mem_rdata", mem_rdata, 64'h1111_2222_3333_4444);
    chk("arb_if_ready_0", 64'(if_ready), 64'd0);
    chk("arb_if_rdata_keep", if_rdata, 64'h0000_0013_0000_0093);
    mem_valid = 0; r_valid = 0;
    @(negedge clk);
    chk("arb2_ar_valid", 64'(ar_valid), 64'd1);
    chk("arb2_ar_addr", ar_addr, 64'h8000_0040);
    chk("arb2_ar_id", 64'(ar_id), 64'd0);
    chk("arb2_mem_ready_pulse", 64'(mem_ready), 64'd0);
    ar_ready = 1;
    @(negedge clk);
    ar_ready = 0;
    r_valid = 1; r_data = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    chk("arb2_if_ready", 64'(if_ready), 64'd1);
    chk("arb2_if_rdata", if_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("arb2_mem_rdata_keep", mem_rdata, 64'h1111_2222_3333_4444);
    if_valid = 0; r_valid = 0;
    @(negedge clk);

    // store with aw_ready cycle 1, w_ready cycle 3
    mem_valid = 1; mem_wen = 1; mem_addr = 64'h8000_2000;
    mem_wdata = 64'hDEAD_BEEF; mem_wstrb = 8'h0F; mem_size = 3'd2;
    @(negedge clk);
    chk("st_aw_valid", 64'(aw_valid), 64'd1);
    chk("st_w_valid", 64'(w_valid), 64'd1);
    chk("st_aw_addr", aw_addr, 64'h8000_2000);
    chk("st_aw_id", 64'(aw_id), 64'd1);
    chk("st_w_data", w_data, 64'hDEAD_BEEF);
    chk("st_w_strb", 64'(w_strb), 64'h0F);
    chk("st_w_last", 64'(w_last), 64'd1);
    chk("st_b_ready_early", 64'(b_ready), 64'd0);
    aw_ready = 1;
    @(negedge clk);
    aw_ready = 0;
    chk("st_aw_drop", 64'(aw_valid), 64'd0);
    chk("st_w_hold", 64'(w_valid), 64'd1);
    chk("st_b_ready_wait", 64'(b_ready), 64'd0);
    @(negedge clk);
    chk("st_w_hold2", 64'(w_valid), 64'd1);
    chk("st_aw_stay_low", 64'(aw_valid), 64'd0);
    w_ready = 1;
    @(negedge clk);
    w_ready = 0;
    chk("st_w_drop", 64'(w_valid), 64'd0);
    chk("st_b_ready", 64'(b_ready), 64'd1);
    chk("st_mem_ready_early", 64'(mem_ready), 64'd0);
    b_valid = 1; b_resp = 2'b00;
    @(negedge clk);
    chk("st_mem_ready", 64'(mem_ready), 64'd1);
    chk("st_b_ready_off", 64'(b_ready), 64'd0);
    chk("st_mem_rdata_keep", mem_rdata, 64'h1111_2222_3333_4444);
`ifdef AXI_BRIDGE_ERR_EN
    chk("st_mem_err_ok", 64'(mem_err), 64'd0);
`endif
    mem_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("st_mem_ready_pulse", 64'(mem_ready), 64'd0);

    // store answered with SLVERR
    mem_valid = 1; mem_wen = 1; mem_addr = 64'h8000_3000;
    mem_wdata = 64'h1234; mem_wstrb = 8'hFF; mem_size = 3'd3;
    @(negedge clk);
    aw_ready = 1; w_ready = 1;
    @(negedge clk);
    aw_ready = 0; w_ready = 0;
    chk("se_b_ready", 64'(b_ready), 64'd1);
    b_valid = 1; b_resp = 2'b10;
    @(negedge clk);
    chk("se_mem_ready", 64'(mem_ready), 64'd1);
`ifdef AXI_BRIDGE_ERR_EN
    chk("se_mem_err", 64'(mem_err), 64'd1);
`endif
    mem_valid = 0; b_valid = 0; b_resp = 2'b00;
    @(negedge clk);

    // reset during RD_DATA abandons the fetch
    if_valid = 1; if_addr = 64'h8000_0080;
    @(negedge clk);
    ar_ready = 1;
    @(negedge clk);
    ar_ready = 0;
    chk("rr_r_ready", 64'(r_ready), 64'd1);
    rst = 1; r_valid = 1; r_data = 64'h5555_5555_5555_5555;
    @(negedge clk);
    chk("rr_r_ready_off", 64'(r_ready), 64'd0);
    chk("rr_ar_valid", 64'(ar_valid), 64'd0);
    chk("rr_aw_valid", 64'(aw_valid), 64'd0);
    chk("rr_if_ready", 64'(if_ready), 64'd0);
    chk("rr_if_rdata", if_rdata, 64'd0);
    chk("rr_mem_rdata", mem_rdata, 64'd0);
    rst = 0; if_valid = 0; r_valid = 0;
    @(negedge clk);
    chk("rr_if_ready_after", 64'(if_ready), 64'd0);
    chk("rr_idle_ar", 64'(ar_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
